mult_rr_scheduler: RTL and testbench
====================================

Name: mult_rr_scheduler

Overview:
- Shares one pipelined array_multiplier instance between NUM_REQ requesters.
- Round-robin arbitration; issues at most one operand pair per cycle into the multiplier.
- Tracks each request's requester ID through the multiplier pipeline and routes the product back as a one-hot response.
- Sits between requester blocks and the multiplier datapath, with the same clock/reset domain as the multiplier.

Parameters:
- DATAWIDTH, 4, operand width; product width is 2*DATAWIDTH.
- NUM_REQ, 4, number of requesters, range 2..16.
- MUL_LATENCY, 2, cycles from multiplier i_valid to o_valid. Must match the attached multiplier's NUM_PIPELINE_STAGES configuration; minimum 1.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_a  input  NUM_REQ*DATAWIDTH  packed operand A; slice i belongs to requester i.
- req_b  input  NUM_REQ*DATAWIDTH  packed operand B; slice i belongs to requester i.
- req_ready  output  NUM_REQ  one-hot grant; transfer occurs when req_valid[i] && req_ready[i].
- m_valid  output  1  to multiplier i_valid.
- m_a  output  DATAWIDTH  to multiplier A.
- m_b  output  DATAWIDTH  to multiplier B.
- m_z  input  2*DATAWIDTH  from multiplier Z_final.
- m_o_valid  input  1  from multiplier o_valid.
- resp_valid  output  NUM_REQ  one-hot response strobe.
- resp_z  output  2*DATAWIDTH  product, broadcast to all requesters.
- busy  output  1  high while any request is in flight.

Behaviour:
- Reset (synchronous): req_ready=0, m_valid=0, m_a=0, m_b=0, resp_valid=0, resp_z=0, busy=0, RR pointer=0, tag pipe cleared. Products in flight are discarded; the multiplier shares the same rst.

Arbitration:
- Combinational from req_valid and the RR pointer.
- Search starts at the pointer and wraps modulo NUM_REQ; the first set req_valid wins.
- req_ready is one-hot of the winner, or zero if no request is pending.
- req_ready must not depend on req_a or req_b.
- On a transfer, the pointer becomes (winner+1) mod NUM_REQ on the next edge; with no transfer it holds.
- A single requester holding valid is granted every cycle.
- Once a requester's request is pending, it is granted within NUM_REQ cycles (fairness).

Issue:
- Registered. On a transfer, next cycle: m_valid=1, m_a/m_b = the winner's slices.
- Otherwise m_valid=0 and m_a/m_b hold their previous values.

Tag pipe:
- Shift register of depth MUL_LATENCY; each entry is {valid, id[$clog2(NUM_REQ)-1:0]}.
- Entry 0 loads {m_valid, issued id} in step with m_valid.

Response:
- When the tag pipe output is valid, then in that same cycle:
  - resp_valid = one-hot(id), driven combinationally from the pipe output, aligned with m_o_valid;
  - resp_z = m_z.
- resp_valid=0 otherwise; resp_z holds its last value.
- There is no response backpressure; requesters must accept a response in the cycle it is presented.
- Resulting latency: req transfer edge to resp_valid is 1+MUL_LATENCY cycles.

Other rules:
- busy = OR of all tag-pipe valid bits and m_valid.
- Simultaneous issue and retire in the same cycle is legal; throughput is 1 per cycle.
- Arithmetic is performed entirely by the multiplier; the block does no width extension or truncation.

Optional Feature:
- Macro: MULT_SCHED_CHECK_EN.
- Defined: adds output err_sticky (1 bit, resets to 0). It sets and stays set until rst whenever m_o_valid differs from the tag pipe output valid in any cycle. A simulation-only $error fires on the first mismatch.
- Undefined: port and logic are absent, and m_o_valid is unused apart from lint waiver.
- Response timing is identical in both builds.

Decomposition:
- Package mult_sched_pkg holds:
  - ID_W = $clog2(NUM_REQ), via a function taking NUM_REQ;
  - the tag struct {valid, id};
  - an onehot-from-id function.
- Sub-module rr_arbiter (parameter N; ports clk, rst, req, advance, grant). It contains the pointer register and the wrap-around priority search.
- The top contains the issue register, the tag pipe and response routing.

Test Plan:
1. Reset mid-operation: issue 3 requests, assert rst on the cycle after the last issue. Required: resp_valid stays 0, busy=0 after reset, pointer=0; next single req from requester 2 is granted.
2. Single requester, DATAWIDTH=4, MUL_LATENCY=2: req 1 with A=3, B=5 for one cycle. Required: req_ready=4'b0010 that cycle; resp_valid=4'b0010 with resp_z=8'd15 exactly 3 cycles after the transfer edge.
3. All four req_valid held high for 8 cycles with A=i+1, B=2. Required:
   - grant order 0,1,2,3,0,1,2,3;
   - responses in the same order with products 2,4,6,8 repeating;
   - one response per cycle, busy high throughout.
4. Wrap-around: pointer=3, req_valid=4'b1001. Required: grant 3 first, then 0; pointer returns to 1.
5. Boundary operands: A=B=4'hF from requester 0 back-to-back with A=0, B=4'hF from requester 1. Required: resp_z=8'hE1 to req0, then 8'h00 to req1, on consecutive cycles.
6. MULT_SCHED_CHECK_EN defined: force m_o_valid high for one cycle with the tag pipe empty. Required: err_sticky=1 from the next cycle until rst, and normal traffic still completes correctly.

Source files
------------

// File: rtl/mult_sched_pkg.sv
// Shared types and helpers for the round-robin multiplier scheduler:
// requester-ID width, the in-flight tag record and the ID-to-one-hot decoder.
package mult_sched_pkg;

    // Tags are sized for the largest supported requester count (16).
    localparam int TAG_ID_W = 4;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic logic [(1<<TAG_ID_W)-1:0] onehot_from_id(input logic [TAG_ID_W-1:0] id);
        return {{((1<<TAG_ID_W)-1){1'b0}}, 1'b1} << id;
    endfunction

endpackage

// File: rtl/mult_rr_scheduler_arb.sv
// Round-robin arbiter: the search starts at the pointer and wraps; the pointer
// moves one past the winner whenever a grant is taken.
module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int ID_W = id_width(N);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        grant = '0;
        win   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
            idx = (idx == ID_W'(N - 1)) ? '0 : idx + ID_W'(1);
        end
        // No grants while reset is held, so nothing transfers into a clearing pipe.
        if (found && !rst) begin
            grant[win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (win == ID_W'(N - 1)) ? '0 : win + ID_W'(1);
        end
    end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one pipelined multiplier among NUM_REQ requesters with round-robin issue
// and ID-tagged response routing. Optional checker: define MULT_SCHED_CHECK_EN.
module mult_rr_scheduler
    import mult_sched_pkg::*;
#(
    parameter int DATAWIDTH   = 4,
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           m_valid,
    output logic [DATAWIDTH-1:0]           m_a,
    output logic [DATAWIDTH-1:0]           m_b,
    input  logic [2*DATAWIDTH-1:0]         m_z,
    input  logic                           m_o_valid,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic [2*DATAWIDTH-1:0]         resp_z,
    output logic                           busy
`ifdef MULT_SCHED_CHECK_EN
    ,
    output logic                           err_sticky
`endif
);

    localparam int ID_W = id_width(NUM_REQ);

    logic                  xfer;
    logic [ID_W-1:0]       win_id;
    logic [ID_W-1:0]       issue_id_p1;
    tag_t                  tag_pipe [MUL_LATENCY];
    tag_t                  tail;
    logic                  resp_fire;
    logic [2*DATAWIDTH-1:0] resp_z_q;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (xfer),
        .grant   (req_ready)
    );

    assign xfer = |(req_valid & req_ready);

    always_comb begin
        win_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    // Stage p1: issue register feeding the multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid     <= 1'b0;
            m_a         <= '0;
            m_b         <= '0;
            issue_id_p1 <= '0;
        end else begin
            m_valid <= xfer;
            if (xfer) begin
                m_a         <= req_a[win_id*DATAWIDTH +: DATAWIDTH];
                m_b         <= req_b[win_id*DATAWIDTH +: DATAWIDTH];
                issue_id_p1 <= win_id;
            end
        end
    end

    // Tag pipe: shadows the multiplier so the tail lines up with m_o_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MUL_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= {m_valid, TAG_ID_W'(issue_id_p1)};
            for (int i = 1; i < MUL_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign tail      = tag_pipe[MUL_LATENCY-1];
    assign resp_fire = tail.valid && !rst;

    // Response: routed combinationally from the tag pipe output.
    assign resp_valid = resp_fire ? NUM_REQ'(onehot_from_id(tail.id)) : '0;
    assign resp_z     = resp_fire ? m_z : resp_z_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_z_q <= '0;
        end else if (resp_fire) begin
            resp_z_q <= m_z;
        end
    end

    always_comb begin
        busy = m_valid;
        for (int i = 0; i < MUL_LATENCY; i++) begin
            busy = busy | tag_pipe[i].valid;
        end
    end

`ifdef MULT_SCHED_CHECK_EN
    logic mismatch;
    assign mismatch = (m_o_valid != tail.valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else begin
            err_sticky <= err_sticky | mismatch;
`ifndef SYNTHESIS
            if (mismatch && !err_sticky) begin
                $error("mult_rr_scheduler: m_o_valid disagrees with tag pipe");
            end
`endif
        end
    end
`else
    logic unused_m_o_valid;
    assign unused_m_o_valid = m_o_valid;
`endif

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed bench for mult_rr_scheduler with a 2-stage multiplier model
// attached to the m_* interface.
module tb_mult_rr_scheduler;

    localparam int DW = 4;
    localparam int NR = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NR-1:0]      req_valid;
    logic [NR*DW-1:0]   req_a;
    logic [NR*DW-1:0]   req_b;
    logic [NR-1:0]      req_ready;
    logic               m_valid;
    logic [DW-1:0]      m_a;
    logic [DW-1:0]      m_b;
    logic [2*DW-1:0]    m_z;
    logic               m_o_valid;
    logic [NR-1:0]      resp_valid;
    logic [2*DW-1:0]    resp_z;
    logic               busy;
`ifdef MULT_SCHED_CHECK_EN
    logic               err_sticky;
`endif

    logic               force_ov;
    logic               mv_s0, mv_s1;
    logic [2*DW-1:0]    mz_s0, mz_s1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mult_rr_scheduler #(
        .DATAWIDTH   (DW),
        .NUM_REQ     (NR),
        .MUL_LATENCY (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .m_valid    (m_valid),
        .m_a        (m_a),
        .m_b        (m_b),
        .m_z        (m_z),
        .m_o_valid  (m_o_valid),
        .resp_valid (resp_valid),
        .resp_z     (resp_z),
        .busy       (busy)
`ifdef MULT_SCHED_CHECK_EN
        ,
        .err_sticky (err_sticky)
`endif
    );

    // Multiplier model: two register stages, valid in cycle c -> product in cycle c+2.
    always @(posedge clk) begin
        if (rst) begin
            mv_s0 <= 1'b0;
            mv_s1 <= 1'b0;
            mz_s0 <= '0;
            mz_s1 <= '0;
        end else begin
            mv_s0 <= m_valid;
            mz_s0 <= m_a * m_b;
            mv_s1 <= mv_s0;
            mz_s1 <= mz_s0;
        end
    end
    assign m_o_valid = mv_s1 | force_ov;
    assign m_z       = mz_s1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #2;
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    logic [NR-1:0]   grant_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [2*DW-1:0] prod_tab  [4] = '{8'd2, 8'd4, 8'd6, 8'd8};

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        force_ov  = 1'b0;
        adv();
        adv();

        // Reset state
        chk("rst_req_ready",  32'(req_ready),  32'h0);
        chk("rst_m_valid",    32'(m_valid),    32'h0);
        chk("rst_m_a",        32'(m_a),        32'h0);
        chk("rst_m_b",        32'(m_b),        32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_z",     32'(resp_z),     32'h0);
        chk("rst_busy",       32'(busy),       32'h0);
        rst = 1'b0;
        adv();

        // Single requester 1: 3*5
        set_op(1, 4'd3, 4'd5);
        req_valid = 4'b0010;
        #1;
        chk("single_grant", 32'(req_ready), 32'h2);
        adv();
        req_valid = '0;
        #1;
        chk("single_m_valid", 32'(m_valid), 32'h1);
        chk("single_m_a",     32'(m_a),     32'h3);
        chk("single_m_b",     32'(m_b),     32'h5);
        adv();
        chk("single_early_resp", 32'(resp_valid), 32'h0);
        adv();
        chk("single_resp_valid", 32'(resp_valid), 32'h2);
        chk("single_resp_z",     32'(resp_z),     32'd15);
        chk("single_busy",       32'(busy),       32'h1);
        adv();
        chk("single_resp_off",   32'(resp_valid), 32'h0);
        chk("single_z_hold",     32'(resp_z),     32'd15);
        chk("single_idle",       32'(busy),       32'h0);
        chk("single_m_valid_lo", 32'(m_valid),    32'h0);
        chk("single_m_a_hold",   32'(m_a),        32'h3);

        // Wrap-around: move pointer to 3, then 1001 grants 3 then 0
        req_valid = 4'b0100;
        #1;
        chk("wrap_pre_grant", 32'(req_ready), 32'h4);
        adv();
        req_valid = 4'b1001;
        #1;
        chk("wrap_ptr3",   32'(dut.u_arb.ptr), 32'd3);
        chk("wrap_grant3", 32'(req_ready),     32'h8);
        adv();
        chk("wrap_grant0", 32'(req_ready),     32'h1);
        adv();
        req_valid = '0;
        #1;
        chk("wrap_ptr1",   32'(dut.u_arb.ptr), 32'd1);
        for (int i = 0; i < 4; i++) adv();
        chk("wrap_drained", 32'(busy), 32'h0);

        // Boundary operands, back-to-back from requesters 0 and 1
        set_op(0, 4'hF, 4'hF);
        set_op(1, 4'h0, 4'hF);
        req_valid = 4'b0001;
        #1;
        chk("bnd_grant0", 32'(req_ready), 32'h1);
        adv();
        req_valid = 4'b0010;
        #1;
        chk("bnd_grant1", 32'(req_ready), 32'h2);
        adv();
        req_valid = '0;
        adv();
        chk("bnd_resp0_valid", 32'(resp_valid), 32'h1);
        chk("bnd_resp0_z",     32'(resp_z),     32'hE1);
        adv();
        chk("bnd_resp1_valid", 32'(resp_valid), 32'h2);
        chk("bnd_resp1_z",     32'(resp_z),     32'h00);
        adv();
        req_valid = 4'b1000;
        adv();
        req_valid = '0;
        for (int i = 0; i < 4; i++) adv();
        chk("burst_ptr0", 32'(dut.u_arb.ptr), 32'd0);

        // All four requesters for 8 cycles
        for (int i = 0; i < NR; i++) set_op(i, DW'(i + 1), 4'd2);
        req_valid = 4'b1111;
        for (int t = 0; t < 11; t++) begin
            if (t == 8) req_valid = '0;
            #1;
            if (t < 8)
                chk($sformatf("burst_grant_t%0d", t), 32'(req_ready), 32'(grant_tab[t % 4]));
            if (t < 3)
                chk($sformatf("burst_noresp_t%0d", t), 32'(resp_valid), 32'h0);
            else begin
                chk($sformatf("burst_resp_t%0d", t), 32'(resp_valid), 32'(grant_tab[(t - 3) % 4]));
                chk($sformatf("burst_z_t%0d", t),    32'(resp_z),     32'(prod_tab[(t - 3) % 4]));
            end
            if (t >= 1)
                chk($sformatf("burst_busy_t%0d", t), 32'(busy), 32'h1);
            adv();
        end
        chk("burst_end_busy", 32'(busy),       32'h0);
        chk("burst_end_resp", 32'(resp_valid), 32'h0);

        // Reset mid-operation
        set_op(0, 4'd1, 4'd1);
        set_op(1, 4'd1, 4'd2);
        set_op(2, 4'd1, 4'd3);
        req_valid = 4'b0001;
        adv();
        req_valid = 4'b0010;
        adv();
        req_valid = 4'b0100;
        adv();
        req_valid = '0;
        rst = 1'b1;
        #1;
        chk("mrst_resp_during", 32'(resp_valid), 32'h0);
        adv();
        rst = 1'b0;
        #1;
        chk("mrst_busy",    32'(busy),           32'h0);
        chk("mrst_ptr",     32'(dut.u_arb.ptr),  32'd0);
        chk("mrst_m_valid", 32'(m_valid),        32'h0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mrst_noresp_%0d", i), 32'(resp_valid), 32'h0);
            adv();
        end
        set_op(2, 4'd2, 4'd3);
        req_valid = 4'b0100;
        #1;
        chk("mrst_grant2", 32'(req_ready), 32'h4);
        adv();
        req_valid = '0;
        adv();
        adv();
        chk("mrst_resp2_valid", 32'(resp_valid), 32'h4);
        chk("mrst_resp2_z",     32'(resp_z),     32'd6);
        adv();

`ifdef MULT_SCHED_CHECK_EN
        // Spurious multiplier valid with the tag pipe empty
        chk("chk_err_clear", 32'(err_sticky), 32'h0);
        force_ov = 1'b1;
        adv();
        force_ov = 1'b0;
        #1;
        chk("chk_err_set", 32'(err_sticky), 32'h1);
        set_op(1, 4'd7, 4'd3);
        req_valid = 4'b0010;
        adv();
        req_valid = '0;
        adv();
        adv();
        chk("chk_traffic_valid", 32'(resp_valid), 32'h2);
        chk("chk_traffic_z",     32'(resp_z),     32'h15);
        chk("chk_err_stays",     32'(err_sticky), 32'h1);
        adv();
        rst = 1'b1;
        adv();
        rst = 1'b0;
        #1;
        chk("chk_err_rst", 32'(err_sticky), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
